// File: rtl/spmv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : spmv_pkg
//  Description : Shared types for the SpMV datapath. Holds the row-reducer
//                state encoding used by spmv_row_reducer.
//  Contents    : spmv_reducer_state_enum - IDLE / RUN / DRAIN / DONE
//  Revision    : 1.0 - initial release
// ============================================================================
package spmv_pkg;

  typedef enum logic [1:0] {
    RED_IDLE  = 2'd0,
    RED_RUN   = 2'd1,
    RED_DRAIN = 2'd2,
    RED_DONE  = 2'd3
  } spmv_reducer_state_enum;

endpackage : spmv_pkg
`default_nettype wire

// File: rtl/spmv_row_reducer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : spmv_row_reducer_if
//  Description : Product-beat input channel and x_n write channel of the
//                row reducer.
//  Signals     : in_valid/in_ready   - beat handshake
//                in_data             - PARALLELISM signed products
//                in_row              - row index per lane
//                in_mask             - per-lane active flag
//                in_last             - final beat of the pass
//                out_valid/out_ready - row-sum write handshake
//                out_addr/out_data   - row index and row sum
//  Modports    : master - producer of beats / consumer of writes
//                slave  - the reducer
//  Revision    : 1.0 - initial release
// ============================================================================
interface spmv_row_reducer_if #(
  parameter int LENGTH      = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 4
);
  localparam int ADDR_WIDTH = $clog2(LENGTH);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  logic                                   in_valid;
  logic                                   in_ready;
  logic [PARALLELISM-1:0][PROD_WIDTH-1:0] in_data;
  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] in_row;
  logic [PARALLELISM-1:0]                 in_mask;
  logic                                   in_last;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [ADDR_WIDTH-1:0]                  out_addr;
  logic [PROD_WIDTH-1:0]                  out_data;

  modport master (
    output in_valid, in_data, in_row, in_mask, in_last, out_ready,
    input  in_ready, out_valid, out_addr, out_data
  );

  modport slave (
    input  in_valid, in_data, in_row, in_mask, in_last, out_ready,
    output in_ready, out_valid, out_addr, out_data
  );

endinterface : spmv_row_reducer_if
`default_nettype wire

// File: rtl/spmv_segment_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : spmv_segment_reduce
//  Description : Combinational segmented reduction of one product beat.
//                Active lanes are grouped in lane order into runs of equal
//                row; the run continuing the carried open row absorbs acc.
//                Completed runs are reported in slots: slot 0 is the carried
//                row closing on its own, slot i+1 is a run ending at lane i.
//  Ports       : data_i/row_i/mask_i/last_i - the accepted beat
//                open_vld_i/open_row_i/acc_i - row carried from earlier beats
//                cmp_vld_o/cmp_row_o/cmp_sum_o - completed rows per slot
//                open_vld_o/open_row_o/acc_o - row carried to the next beat
//                order_err_o - an active row is lower than its predecessor
//  Revision    : 1.0 - initial release
// ============================================================================
module spmv_segment_reduce #(
  parameter int ADDR_WIDTH  = 5,
  parameter int PROD_WIDTH  = 64,
  parameter int PARALLELISM = 4
) (
  input  logic [PARALLELISM-1:0][PROD_WIDTH-1:0] data_i,
  input  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] row_i,
  input  logic [PARALLELISM-1:0]                 mask_i,
  input  logic                                   last_i,
  input  logic                                   open_vld_i,
  input  logic [ADDR_WIDTH-1:0]                  open_row_i,
  input  logic [PROD_WIDTH-1:0]                  acc_i,
  output logic [PARALLELISM:0]                   cmp_vld_o,
  output logic [PARALLELISM:0][ADDR_WIDTH-1:0]   cmp_row_o,
  output logic [PARALLELISM:0][PROD_WIDTH-1:0]   cmp_sum_o,
  output logic                                   open_vld_o,
  output logic [ADDR_WIDTH-1:0]                  open_row_o,
  output logic [PROD_WIDTH-1:0]                  acc_o,
  output logic                                   order_err_o
);

  localparam int SLOT_W = $clog2(PARALLELISM + 1);

  always_comb begin : p_reduce
    logic                  run_vld;
    logic [ADDR_WIDTH-1:0] run_row;
    logic [PROD_WIDTH-1:0] run_sum;
    logic [SLOT_W-1:0]     run_slot;

    cmp_vld_o   = '0;
    cmp_row_o   = '0;
    cmp_sum_o   = '0;
    order_err_o = 1'b0;

    // The running segment starts as the carried row, reported in slot 0
    // if it closes before any lane joins it.
    run_vld  = open_vld_i;
    run_row  = open_row_i;
    run_sum  = acc_i;
    run_slot = '0;

    for (int i = 0; i < PARALLELISM; i++) begin
      if (mask_i[i]) begin
        if (run_vld && (row_i[i] == run_row)) begin
          run_sum = run_sum + data_i[i];
        end else begin
          if (run_vld) begin
            cmp_vld_o[run_slot] = 1'b1;
            cmp_row_o[run_slot] = run_row;
            cmp_sum_o[run_slot] = run_sum;
            if (row_i[i] < run_row) begin
              order_err_o = 1'b1;
            end
          end
          run_vld = 1'b1;
          run_row = row_i[i];
          run_sum = data_i[i];
        end
        run_slot = SLOT_W'(i + 1);
      end
    end

    if (last_i && run_vld) begin
      cmp_vld_o[run_slot] = 1'b1;
      cmp_row_o[run_slot] = run_row;
      cmp_sum_o[run_slot] = run_sum;
      open_vld_o          = 1'b0;
      open_row_o          = '0;
      acc_o               = '0;
    end else begin
      open_vld_o = run_vld;
      open_row_o = run_row;
      acc_o      = run_sum;
    end
  end

endmodule : spmv_segment_reduce
`default_nettype wire

// File: rtl/spmv_row_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : spmv_row_reducer
//  Description : Accumulates per-lane signed products into row sums and
//                writes each finished row to x_n. One pass is started by en
//                and ends with a one-cycle done pulse.
//  Parameters  : LENGTH      - rows addressable in x_n
//                DATA_WIDTH  - operand width (sums are 2*DATA_WIDTH wide)
//                PARALLELISM - lanes per input beat
//  Ports       : clk, rst_n (async, active low)
//                en   - start pulse, honoured only in IDLE
//                done - one-cycle end-of-pass pulse
//                bus  - beat input channel and row-sum write channel
//  Revision    : 1.0 - initial release
// ============================================================================
module spmv_row_reducer
  import spmv_pkg::*;
#(
  parameter int LENGTH      = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               done,
  spmv_row_reducer_if.slave  bus
);

  localparam int ADDR_WIDTH = $clog2(LENGTH);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  // One slot per lane plus one for the carried row closing ahead of lane 0.
  localparam int SLOTS      = PARALLELISM + 1;
  localparam int SLOT_W     = $clog2(SLOTS);

  spmv_reducer_state_enum state_q, state_d;

  logic                             open_vld_q, open_vld_d;
  logic [ADDR_WIDTH-1:0]            open_row_q, open_row_d;
  logic [PROD_WIDTH-1:0]            acc_q, acc_d;
  logic                             last_seen_q, last_seen_d;
  logic [SLOTS-1:0]                 q_vld_q, q_vld_d;
  logic [SLOTS-1:0][ADDR_WIDTH-1:0] q_row_q, q_row_d;
  logic [SLOTS-1:0][PROD_WIDTH-1:0] q_sum_q, q_sum_d;
  logic                             out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]            out_addr_q, out_addr_d;
  logic [PROD_WIDTH-1:0]            out_data_q, out_data_d;

  logic [SLOTS-1:0]                 w_cmp_vld;
  logic [SLOTS-1:0][ADDR_WIDTH-1:0] w_cmp_row;
  logic [SLOTS-1:0][PROD_WIDTH-1:0] w_cmp_sum;
  logic                             w_open_vld;
  logic [ADDR_WIDTH-1:0]            w_open_row;
  logic [PROD_WIDTH-1:0]            w_acc;
  logic                             w_order_err;
  logic                             w_accept;
  logic                             w_fire;

  spmv_segment_reduce #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PROD_WIDTH  (PROD_WIDTH),
    .PARALLELISM (PARALLELISM)
  ) u_segment_reduce (
    .data_i      (bus.in_data),
    .row_i       (bus.in_row),
    .mask_i      (bus.in_mask),
    .last_i      (bus.in_last),
    .open_vld_i  (open_vld_q),
    .open_row_i  (open_row_q),
    .acc_i       (acc_q),
    .cmp_vld_o   (w_cmp_vld),
    .cmp_row_o   (w_cmp_row),
    .cmp_sum_o   (w_cmp_sum),
    .open_vld_o  (w_open_vld),
    .open_row_o  (w_open_row),
    .acc_o       (w_acc),
    .order_err_o (w_order_err)
  );

  assign bus.in_ready  = (state_q == RED_RUN);
  assign done          = (state_q == RED_DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;

  assign w_accept = (state_q == RED_RUN) && bus.in_valid;
  assign w_fire   = out_valid_q && bus.out_ready;

  always_comb begin : p_next
    logic [SLOT_W-1:0] sel;
    logic              found;

    state_d     = state_q;
    open_vld_d  = open_vld_q;
    open_row_d  = open_row_q;
    acc_d       = acc_q;
    last_seen_d = last_seen_q;
    q_vld_d     = q_vld_q;
    q_row_d     = q_row_q;
    q_sum_d     = q_sum_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    sel         = '0;
    found       = 1'b0;

    case (state_q)
      RED_IDLE: begin
        if (en) begin
          state_d     = RED_RUN;
          open_vld_d  = 1'b0;
          open_row_d  = '0;
          acc_d       = '0;
          last_seen_d = 1'b0;
          q_vld_d     = '0;
        end
      end

      RED_RUN: begin
        if (w_accept) begin
          open_vld_d  = w_open_vld;
          open_row_d  = w_open_row;
          acc_d       = w_acc;
          last_seen_d = bus.in_last;
          if (|w_cmp_vld) begin
            // Lowest completed slot goes straight to the output register so
            // the first write appears the cycle after acceptance.
            for (int k = 0; k < SLOTS; k++) begin
              if (!found && w_cmp_vld[k]) begin
                found = 1'b1;
                sel   = SLOT_W'(k);
              end
            end
            out_valid_d  = 1'b1;
            out_addr_d   = w_cmp_row[sel];
            out_data_d   = w_cmp_sum[sel];
            q_vld_d      = w_cmp_vld;
            q_vld_d[sel] = 1'b0;
            q_row_d      = w_cmp_row;
            q_sum_d      = w_cmp_sum;
            state_d      = RED_DRAIN;
          end else if (bus.in_last) begin
            state_d = RED_DONE;
          end
        end
      end

      RED_DRAIN: begin
        if (w_fire) begin
          if (|q_vld_q) begin
            for (int k = 0; k < SLOTS; k++) begin
              if (!found && q_vld_q[k]) begin
                found = 1'b1;
                sel   = SLOT_W'(k);
              end
            end
            out_addr_d   = q_row_q[sel];
            out_data_d   = q_sum_q[sel];
            q_vld_d[sel] = 1'b0;
          end else begin
            out_valid_d = 1'b0;
            state_d     = last_seen_q ? RED_DONE : RED_RUN;
          end
        end
      end

      RED_DONE: begin
        state_d = RED_IDLE;
      end

      default: begin
        state_d = RED_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RED_IDLE;
      open_vld_q  <= 1'b0;
      open_row_q  <= '0;
      acc_q       <= '0;
      last_seen_q <= 1'b0;
      q_vld_q     <= '0;
      q_row_q     <= '0;
      q_sum_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      open_vld_q  <= open_vld_d;
      open_row_q  <= open_row_d;
      acc_q       <= acc_d;
      last_seen_q <= last_seen_d;
      q_vld_q     <= q_vld_d;
      q_row_q     <= q_row_d;
      q_sum_q     <= q_sum_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  // Rows must never decrease across active lanes or beats of a pass.
  a_row_order : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_accept && w_order_err));

endmodule : spmv_row_reducer
`default_nettype wire

// File: doc/spmv_row_reducer.md
SPMV_ROW_REDUCER -- requirements
Module: spmv_row_reducer

Interface
REQ-001 SHALL have parameter LENGTH, default 32: vector length and number of rows addressable in x_n.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: operand width; products and sums are PROD_WIDTH = 2*DATA_WIDTH.
REQ-003 SHALL have parameter PARALLELISM, default 4: lanes per input beat.
REQ-004 SHALL derive localparam ADDR_WIDTH = $clog2(LENGTH).
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1: start pulse for one matrix pass.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the pass has completed.
REQ-009 SHALL have port in_valid, input, 1: product beat valid.
REQ-010 SHALL have port in_ready, output, 1: beat accepted on in_valid && in_ready.
REQ-011 SHALL have port in_data, input, PARALLELISM x PROD_WIDTH: signed products, one per lane.
REQ-012 SHALL have port in_row, input, PARALLELISM x ADDR_WIDTH: row index for each lane.
REQ-013 SHALL have port in_mask, input, PARALLELISM: per-lane active flag.
REQ-014 SHALL have port in_last, input, 1: final beat of the pass.
REQ-015 SHALL have port out_valid, output, 1: row-sum write valid toward x_n.
REQ-016 SHALL have port out_ready, input, 1: x_n write accepted.
REQ-017 SHALL have port out_addr, output, ADDR_WIDTH: row index of the write.
REQ-018 SHALL have port out_data, output, PROD_WIDTH: row sum.

Function
REQ-019 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE: in_ready=0; on en, go to RUN and clear the open-row register (open_vld=0, acc=0).
REQ-021 RUN: in_ready=1; en is ignored outside IDLE.
REQ-022 On an accepted beat, active lanes SHALL be grouped in lane order into maximal runs of equal in_row (segments).
REQ-023 A segment whose row equals the open row SHALL add the carried acc; inactive lanes contribute nothing.
REQ-024 All segments except the last SHALL complete and be queued; the last segment becomes the new open row.
REQ-025 If in_last is set, the last segment (or the carried open row when no lane is active) SHALL also complete.
REQ-026 If any segment completes, the block SHALL go to DRAIN the cycle after acceptance.
REQ-027 Otherwise it SHALL stay in RUN, or go to DONE on in_last with nothing to write.
REQ-028 DRAIN: in_ready=0; emit queued rows in ascending lane order, one per out_valid && out_ready.
REQ-029 When the queue is empty, DRAIN SHALL go to DONE if the last beat has been seen, otherwise to RUN.
REQ-030 out_valid, out_addr and out_data SHALL be registered, with first out_valid one cycle after the accepting edge.
REQ-031 out_valid, out_addr and out_data SHALL be held stable while out_valid && !out_ready.
REQ-032 DONE: done=1 for exactly one cycle, then IDLE.
REQ-033 Summation SHALL wrap modulo 2^PROD_WIDTH (two's complement); there is no saturation and no overflow flag.
REQ-034 The queue SHALL hold PARALLELISM entries, enough for one beat in which every lane is a different row with in_last set.
REQ-035 Rows with no active lane SHALL produce no write; x_n is zero-filled by its owner beforehand.
REQ-036 in_row SHALL be non-decreasing across active lanes and beats; a simulation-only assertion SHALL flag any decrease.
REQ-037 A beat with an all-zero in_mask and no in_last SHALL be accepted with no effect.

Reset
REQ-038 rst_n low SHALL force, asynchronously, state IDLE, queue empty, open_vld=0 and acc=0.
REQ-039 rst_n low SHALL force done=0, in_ready=0, out_valid=0, out_addr=0 and out_data=0.
REQ-040 Reset mid-pass SHALL discard all partial sums; the next en starts a clean pass.

Structure
REQ-041 spmv_pkg SHALL add spmv_reducer_state_enum {RED_IDLE, RED_RUN, RED_DRAIN, RED_DONE}.
REQ-042 The combinational segmented reduction (lane sums, segment-end flags, carry merge) SHALL be a sub-module named spmv_segment_reduce.
REQ-043 The FSM, queue and output registers SHALL remain in spmv_row_reducer.

Verification (PARALLELISM=4)
REQ-044 Rows {0,0,0,0}, data {1,2,3,4}, mask 1111, last -> single write (0,10), then done pulse.
REQ-045 Beat rows {2,1,1,0} (lane3..0), data {4,3,2,1} -> writes (0,1),(1,5); then beat rows {3,3,2,2}, data {8,7,6,5}, last -> writes (2,15),(3,15), done.
REQ-046 Beat rows {3,2,1,0} with last, out_ready=0 for 5 cycles -> out_valid held on (0,·) with stable data, in_ready=0, then four writes in order with none lost.
REQ-047 Rows {6,6,5,5}, mask 0101, data {x,20,x,10}, last -> writes (5,10),(6,20).
REQ-048 DATA_WIDTH=8, one row, products 0xFFFF and 0x0002, last -> write data 0x0001.
REQ-049 Assert rst_n in DRAIN with 2 entries queued -> out_valid=0 immediately, no further writes; re-en with case REQ-044 -> (0,10).
